alu_ctrl: RTL
=============

# alu_ctrl

Multi-cycle issue controller that sits in front of the registered 8-bit ALU and acts as its initiator. It accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 4x8 register file, and drives `func`/`spec_fun`/operands into the ALU. It captures the ALU's registered `res`/`br_out` one cycle later, then writes the result back or redirects the program counter.

## Interface
- No parameters; all widths are fixed.
- `clock`  in  1  single clock domain; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  instruction word present.
- `instr`  in  16  [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [5:0] imm.
  - imm[5:3] = spec_fun for op 0111.
  - imm = signed branch offset for branch ops.
- `instr_ready`  out  1  high only in IDLE.
- `alu_reg1`, `alu_reg2`  out  8  ALU operands: R[rs], R[rt].
- `alu_func`  out  4  ALU func code.
- `alu_spec_fun`  out  3  ALU spec_fun code.
- `alu_res`  in  8  ALU registered result.
- `alu_br`  in  1  ALU registered branch flag.
- `pc`  out  8  program counter.
- `retire`  out  1  1-cycle pulse per completed instruction.
- `illegal`  out  1  1-cycle pulse per rejected instruction.
- `dbg_addr`  in  2  register-file debug read address.
- `dbg_data`  out  8  R[dbg_addr], combinational.

## Operation
- Legal ops: 0000 add, 0011 sll, 0100 slr, 0111 spec, 1010 blt, 1011 be.
- Legal spec_fun values: 000 inc, 001 and1, 011 dec.
- Any other op, or op 0111 with spec_fun in {010, 1xx}, is illegal.
- FSM states IDLE, ISSUE, CAPTURE.
- IDLE:
  - On instr_valid, latch instr.
  - If legal: go to ISSUE.
  - If illegal: stay in IDLE. Next cycle pulse illegal and retire, pc <= pc+1, no register write, no ALU issue.
- ISSUE (1 cycle):
  - alu_func = op, alu_spec_fun = imm[5:3] (000 for non-spec ops), alu_reg1 = R[rs], alu_reg2 = R[rt].
  - The ALU samples these at the end of this cycle.
  - Next state: CAPTURE.
- CAPTURE (1 cycle): alu_res/alu_br are valid; at the closing edge:
  - add/sll/slr/spec: R[rd] <= alu_res, pc <= pc+1.
  - blt/be: if alu_br, pc <= pc + sext(imm); otherwise pc <= pc+1. No register write.
  - Pulse retire; next state IDLE.
- alu_* outputs are registered and hold their last values outside ISSUE.
- All arithmetic is mod 256. PC wraps 255 -> 0. Negative offsets wrap (pc=2, imm=111110 -> 0).
- All four registers (R0-R3) are writable; there is no hardwired zero.
- instr_valid while instr_ready=0 is ignored; the word is not latched. The source must hold it until it sees ready.
- Same register as source and destination (rs = rd): the operand is read in ISSUE and written in CAPTURE, so no hazard.
- Debug read while R[dbg_addr] is being written returns the old value until the edge.

## Timing
- Legal instruction accepted at edge E0: ISSUE during E0-E1, CAPTURE during E1-E2.
  - retire is high during E2-E3; writeback and pc are visible after E2; instr_ready rises after E2.
  - Throughput is 1 instruction per 3 cycles.
- Illegal instruction accepted at E0: illegal and retire are high during E0-E1; pc is updated at E1. instr_ready stays high.
- Reset values (asynchronous): state IDLE, instr_ready 1, R0-R3 0, pc 0, alu_reg1/alu_reg2/alu_func/alu_spec_fun 0, retire 0, illegal 0.
- Reset asserted during ISSUE or CAPTURE aborts the instruction: no writeback and no retire. The first cycle after deassertion is IDLE.

## Test plan
- Reset then add: preload R1=200 and R2=100 via inc sequences; add rd=R3, rs=R1, rt=R2.
  - R3=44 (wrap); retire exactly 3 cycles after accept; pc +1.
- Shifts and spec ops:
  - R1=0x81, sll by R2=1 -> 0x02; slr -> 0x40.
  - inc of 0xFF -> 0x00; dec of 0x00 -> 0xFF; and1 of 0x81 -> 0x01.
- Branches:
  - be with equal operands and imm=+5 at pc=10 -> pc=15.
  - blt with R[rs]=7, R[rt]=3 -> pc=11.
  - be with imm=-3 at pc=1 -> pc=254.
- Illegal: op 0001 and op 0111 with spec_fun 100.
  - illegal pulse 1 cycle after accept; no register change; pc +1; ready never drops.
- Handshake: toggle instr_valid during ISSUE/CAPTURE with different words.
  - Only the word present while ready=1 is executed.
  - Back-to-back valid yields exactly one retire per 3 cycles.
- Reset mid-op: assert reset in CAPTURE of add to R0=5.
  - R0 stays 0, pc stays 0, retire does not pulse, ready=1 after reset.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Instruction handshake and ALU issue/result bus between alu_ctrl and its environment.
// The controller takes the slave view; the instruction source and the ALU take the master view.
interface alu_ctrl_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_reg1;
    logic [7:0]  alu_reg2;
    logic [3:0]  alu_func;
    logic [2:0]  alu_spec_fun;
    logic [7:0]  alu_res;
    logic        alu_br;

    modport slave (
        input  instr_valid,
        input  instr,
        input  alu_res,
        input  alu_br,
        output instr_ready,
        output alu_reg1,
        output alu_reg2,
        output alu_func,
        output alu_spec_fun
    );

    modport master (
        output instr_valid,
        output instr,
        output alu_res,
        output alu_br,
        input  instr_ready,
        input  alu_reg1,
        input  alu_reg2,
        input  alu_func,
        input  alu_spec_fun
    );
endinterface

// File: rtl/alu_ctrl.sv
// Multi-cycle issue controller: decodes 16-bit instructions, drives a registered ALU,
// then writes the result into a 4x8 register file or redirects the program counter.
module alu_ctrl (
    input  logic        clock,
    input  logic        reset,
    alu_ctrl_if.slave   bus,
    output logic [7:0]  pc,
    output logic        retire,
    output logic        illegal,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLR  = 4'b0100;
    localparam logic [3:0] OP_SPEC = 4'b0111;
    localparam logic [3:0] OP_BLT  = 4'b1010;
    localparam logic [3:0] OP_BE   = 4'b1011;

    localparam logic [2:0] SF_INC  = 3'b000;
    localparam logic [2:0] SF_AND1 = 3'b001;
    localparam logic [2:0] SF_DEC  = 3'b011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    logic [3:0]  op_reg, op_next;
    logic [1:0]  dst_reg, dst_next;
    logic [5:0]  imm_reg, imm_next;
    logic [7:0]  pc_reg, pc_next;
    logic        retire_reg, retire_next;
    logic        illegal_reg, illegal_next;
    logic [7:0]  reg1_reg, reg1_next;
    logic [7:0]  reg2_reg, reg2_next;
    logic [3:0]  func_reg, func_next;
    logic [2:0]  spec_reg, spec_next;

    logic [7:0]  rf_reg [4];
    logic [3:0]  wr_sel;
    logic        wr_en;

    logic [3:0]  in_op;
    logic [1:0]  in_rd;
    logic [1:0]  in_rs;
    logic [1:0]  in_rt;
    logic [5:0]  in_imm;
    logic [2:0]  in_sf;
    logic        in_legal;
    logic        cur_branch;
    logic [7:0]  branch_off;

    assign in_op  = bus.instr[15:12];
    assign in_rd  = bus.instr[11:10];
    assign in_rs  = bus.instr[9:8];
    assign in_rt  = bus.instr[7:6];
    assign in_imm = bus.instr[5:0];
    assign in_sf  = in_imm[5:3];

    always_comb begin
        in_legal = 1'b0;
        case (in_op)
            OP_ADD, OP_SLL, OP_SLR, OP_BLT, OP_BE:
                in_legal = 1'b1;
            OP_SPEC:
                in_legal = (in_sf == SF_INC) || (in_sf == SF_AND1) || (in_sf == SF_DEC);
            default:
                in_legal = 1'b0;
        endcase
    end

    assign cur_branch = (op_reg == OP_BLT) || (op_reg == OP_BE);
    assign branch_off = {{2{imm_reg[5]}}, imm_reg};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control; every target holds unless overridden below.
    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        dst_next     = dst_reg;
        imm_next     = imm_reg;
        pc_next      = pc_reg;
        retire_next  = 1'b0;
        illegal_next = 1'b0;
        reg1_next    = reg1_reg;
        reg2_next    = reg2_reg;
        func_next    = func_reg;
        spec_next    = spec_reg;
        wr_en        = 1'b0;

        // A rejected word advances the pc on the cycle its illegal pulse is shown.
        if (illegal_reg) begin
            pc_next = pc_reg + 8'd1;
        end

        case (state_reg)
            IDLE: begin
                if (bus.instr_valid) begin
                    op_next  = in_op;
                    dst_next = in_rd;
                    imm_next = in_imm;
                    if (in_legal) begin
                        state_next = ISSUE;
                        func_next  = in_op;
                        spec_next  = (in_op == OP_SPEC) ? in_sf : 3'b000;
                        reg1_next  = rf_reg[in_rs];
                        reg2_next  = rf_reg[in_rt];
                    end else begin
                        illegal_next = 1'b1;
                        retire_next  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next  = IDLE;
                retire_next = 1'b1;
                if (cur_branch) begin
                    pc_next = pc_reg + (bus.alu_br ? branch_off : 8'd1);
                end else begin
                    pc_next = pc_reg + 8'd1;
                    wr_en   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_reg      <= '0;
            dst_reg     <= '0;
            imm_reg     <= '0;
            pc_reg      <= '0;
            retire_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            reg1_reg    <= '0;
            reg2_reg    <= '0;
            func_reg    <= '0;
            spec_reg    <= '0;
        end else begin
            op_reg      <= op_next;
            dst_reg     <= dst_next;
            imm_reg     <= imm_next;
            pc_reg      <= pc_next;
            retire_reg  <= retire_next;
            illegal_reg <= illegal_next;
            reg1_reg    <= reg1_next;
            reg2_reg    <= reg2_next;
            func_reg    <= func_next;
            spec_reg    <= spec_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (dst_reg == 2'(gi));
        end
    endgenerate

    // Register file needs a reset to zero, so it stays in flops rather than RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_sel[i]) begin
                    rf_reg[i] <= bus.alu_res;
                end
            end
        end
    end

    assign bus.instr_ready  = (state_reg == IDLE);
    assign bus.alu_reg1     = reg1_reg;
    assign bus.alu_reg2     = reg2_reg;
    assign bus.alu_func     = func_reg;
    assign bus.alu_spec_fun = spec_reg;
    assign pc               = pc_reg;
    assign retire           = retire_reg;
    assign illegal          = illegal_reg;
    assign dbg_data         = rf_reg[dbg_addr];

    a_illegal_retires: assert property (@(posedge clock) disable iff (reset)
        illegal_reg |-> retire_reg);
    a_retire_in_idle: assert property (@(posedge clock) disable iff (reset)
        retire_reg |-> (state_reg == IDLE));
    a_state_encoding: assert property (@(posedge clock) disable iff (reset)
        state_reg != 2'd3);
endmodule
